// File: rtl/large_div.sv
// large_div: sequential unsigned restoring divider, one quotient bit per clock.
// Quo/Rem/dbz hold the last result until the next one is loaded.
module large_div #(
  parameter int DW = 16,
  parameter int VW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic [DW-1:0] A,
  input  logic [VW-1:0] B,
  output logic [DW-1:0] Quo,
  output logic [VW-1:0] Rem,
  output logic          busy,
  output logic          done,
  output logic          dbz
);

  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [DW-1:0] sr;          // dividend shifting out, quotient shifting in
  logic [VW-1:0] dvs;         // captured divisor
  logic [VW:0]   prem;        // partial remainder
  logic [CW-1:0] cnt;         // completed iterations

  logic [VW+1:0] shifted_wide;
  logic [VW:0]   shifted;
  logic [VW:0]   diff;
  logic          fits;
  logic [VW:0]   prem_step;
  logic [DW-1:0] sr_step;
  logic          last;
  logic          accept;

  // One restoring iteration: shift left, trial-subtract, keep or restore.
  always_comb begin
    shifted_wide = {prem, sr[DW-1]};
    shifted      = shifted_wide[VW:0];
    fits         = (shifted_wide >= (VW+2)'(dvs));
    diff         = shifted - {1'b0, dvs};
    prem_step    = fits ? diff : shifted;
    sr_step      = {sr[DW-2:0], fits};
    last         = (cnt == CW'(DW - 1));
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; zero divisor skips straight to DONE.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          accept     = 1'b1;
          state_next = (B == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr   <= '0;
      dvs  <= '0;
      prem <= '0;
      cnt  <= '0;
      Quo  <= '0;
      Rem  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      dbz  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            sr   <= A;
            dvs  <= B;
            prem <= '0;
            cnt  <= '0;
            busy <= 1'b1;
            if (B == '0) begin
              // No iterations: saturated quotient, low dividend bits as remainder.
              Quo  <= '1;
              Rem  <= A[VW-1:0];
              dbz  <= 1'b1;
              done <= 1'b1;
            end
          end
        end
        RUN: begin
          sr   <= sr_step;
          prem <= prem_step;
          cnt  <= cnt + CW'(1);
          if (last) begin
            Quo  <= sr_step;
            Rem  <= prem_step[VW-1:0];
            dbz  <= 1'b0;
            done <= 1'b1;
          end
        end
        DONE: begin
          busy <= 1'b0;
        end
        default: begin
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/large_div.md
Name: large_div

Overview:
- Sequential unsigned divider; the inverse operation of the team's combinational 8x8 multiplier.
- Takes a 16-bit dividend and an 8-bit divisor and returns a 16-bit quotient and an 8-bit remainder.
- Uses a restoring shift-subtract algorithm, one quotient bit per clock, with a start/busy/done handshake.
- Sits beside the multiplier in the ALU datapath. Its operand widths let a 16-bit product be divided back by one of its 8-bit factors.

Parameters:
- DW, 16, dividend and quotient width.
- VW, 8, divisor and remainder width (VW <= DW).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  start request; sampled only in IDLE.
- A  input  DW  dividend; captured when start is accepted.
- B  input  VW  divisor; captured when start is accepted.
- Quo  output  DW  quotient register.
- Rem  output  VW  remainder register.
- busy  output  1  high while an operation is in progress (RUN or DONE state).
- done  output  1  one-cycle pulse; results are valid from that cycle on.
- dbz  output  1  divide-by-zero flag for the last result.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset (asynchronous, any state): state=IDLE; Quo=0, Rem=0, busy=0, done=0, dbz=0; iteration counter=0.
- States and transitions:
  - IDLE -> RUN on a clock edge with enable=1, when B!=0.
  - IDLE -> DONE on a clock edge with enable=1, when B==0.
  - RUN -> DONE at the edge that completes iteration DW.
  - DONE -> IDLE unconditionally after one cycle.
- Start accept edge:
  - Latch A into the dividend/quotient shift register.
  - Latch B into the divisor register.
  - Clear the partial remainder (VW+1 bits) and set counter=0.
  - busy=1 from the next cycle.
- RUN, each edge:
  - Shift {partial remainder, shift register} left by one.
  - Trial = partial remainder minus divisor.
  - If trial >= 0: partial remainder = trial and shift-register LSB = 1.
  - Else: keep the partial remainder and set LSB = 0.
  - counter++.
  - After DW iterations: shift register = quotient, partial remainder[VW-1:0] = remainder.
- Result loading:
  - Quo and Rem are loaded at the edge entering DONE.
  - dbz is updated at that same edge.
  - done=1 for exactly the DONE cycle.
  - Quo, Rem and dbz then hold until the next result is loaded; they are not cleared in IDLE.
- Latency:
  - Normal: done is high in the cycle following the (DW+1)th edge counted from the accept edge (17 edges for defaults).
  - Divide-by-zero: done is high in the cycle following the accept edge.
- busy: high in RUN and DONE; low in IDLE. Next accept is possible in the cycle after DONE.
- Divide by zero (B==0): Quo=all ones (16'hFFFF), Rem=A[VW-1:0], dbz=1; no iterations run.
- Valid division: dbz=0. Arithmetic is unsigned. Result satisfies A = Quo*B + Rem with Rem < B.
- enable high while busy (RUN or DONE): ignored; there is no queueing. A and B may change freely after acceptance without affecting the running operation.
- enable held high continuously: a new operation is accepted on every IDLE cycle, i.e. every DW+2 cycles (every 2 cycles for divide-by-zero).
- Reset asserted mid-operation: the operation is aborted immediately, all outputs take reset values, and no done is produced.
- No X outputs are ever driven; all outputs are registered.

Test Plan:
- Reset: hold rst_n=0 two cycles, then release -> Quo=0, Rem=0, busy=0, done=0, dbz=0.
- A=100, B=7, one-cycle enable -> done one cycle wide, 17 edges after accept; Quo=14, Rem=2, dbz=0; busy low the cycle after done.
- Boundary operands:
  - A=65535, B=255 -> Quo=257, Rem=0.
  - A=5, B=9 -> Quo=0, Rem=5.
  - A=65535, B=1 -> Quo=65535, Rem=0.
  - A=0, B=3 -> Quo=0, Rem=0.
- Divide by zero: A=16'h1234, B=0 -> done in the cycle after the accept edge; Quo=16'hFFFF, Rem=8'h34, dbz=1. A following A=10, B=3 -> Quo=3, Rem=1, dbz=0.
- Handshake: A=200, B=10 accepted; pulse enable with A=9, B=3 during RUN -> ignored, result Quo=20, Rem=0. Assert rst_n=0 mid-RUN -> outputs cleared, no done pulse, next operation correct.
- Random loop, 1000 iterations: random A[7:0]*B[7:0] products from the multiplier model plus random R<B used as the dividend -> Quo equals the multiplicand and Rem equals R. enable held high -> back-to-back results every 18 cycles.
